// File: rtl/wb_sram_arb_pkg.sv
// Shared types for the two-port Wishbone to line-enable SRAM arbiter.
package wb_sram_arb_pkg;

  localparam int NUM_PORTS = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arb_state_e;

  // Index of a Wishbone slave port (0 or 1).
  typedef logic arb_idx_t;

endpackage

// File: rtl/generic_sram_line_en_if.sv
// Line-enable SRAM port: one word per access, separate read and write strobes.
interface generic_sram_line_en_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] addr;
  logic              read_en;
  logic              write_en;
  logic [DATA_W-1:0] write_data;
  logic [DATA_W-1:0] read_data;

  modport sram_client (output addr, read_en, write_en, write_data, input read_data);
  modport sram_macro  (input addr, read_en, write_en, write_data, output read_data);
endinterface

// File: rtl/wb_if.sv
// Classic Wishbone bus bundle; the slave modport is the view an SRAM bridge takes.
interface wb_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
);
  logic                cyc;
  logic                stb;
  logic                we;
  logic [ADDR_W-1:0]   adr;
  logic [DATA_W/8-1:0] sel;
  logic [DATA_W-1:0]   dat_w;
  logic [DATA_W-1:0]   dat_r;
  logic                ack;
  logic                err;

  modport slave  (input cyc, stb, we, adr, sel, dat_w, output dat_r, ack, err);
  modport master (output cyc, stb, we, adr, sel, dat_w, input dat_r, ack, err);
endinterface

// File: rtl/wb_sram_arb_rr.sv
// Two-way round-robin grant with a registered priority pointer and an
// optional grant lock that pins arbitration to one port while its CYC stays high.
module wb_sram_arb_rr
  import wb_sram_arb_pkg::*;
(
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [NUM_PORTS-1:0] req,       // CYC & STB per port
  input  logic [NUM_PORTS-1:0] cyc,       // CYC per port, used to release a lock
  input  logic                 upd_en,    // one-cycle pulse when a beat finishes
  input  arb_idx_t             upd_idx,   // port that owned the finished beat
  input  logic                 lock_in,   // keep the grant on upd_idx instead of rotating
  output logic                 gnt_valid,
  output arb_idx_t             gnt_idx
);

  arb_idx_t             ptr_q, ptr_d;
  arb_idx_t             lock_idx_q, lock_idx_d;
  logic                 lock_q, lock_d;
  logic                 lock_hold;
  logic [NUM_PORTS-1:0] req_eff;

  // Grant: a held lock masks the other port; ties go to the pointer.
  always_comb begin
    lock_hold = lock_q && cyc[lock_idx_q];
    req_eff   = req;
    if (lock_hold) req_eff = req & (2'b01 << lock_idx_q);
    gnt_valid = |req_eff;
    gnt_idx   = ptr_q;
    if (req_eff == 2'b01)      gnt_idx = 1'b0;
    else if (req_eff == 2'b10) gnt_idx = 1'b1;
  end

  // Pointer/lock update: rotate after each beat unless the beat locks the grant.
  always_comb begin
    ptr_d      = ptr_q;
    lock_d     = lock_q;
    lock_idx_d = lock_idx_q;
    if (upd_en) begin
      lock_d     = lock_in;
      lock_idx_d = upd_idx;
      if (!lock_in) ptr_d = ~upd_idx;
    end else if (!lock_hold) begin
      lock_d = 1'b0;
    end
  end

  // Arbitration state registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ptr_q      <= 1'b0;
      lock_q     <= 1'b0;
      lock_idx_q <= 1'b0;
    end else begin
      ptr_q      <= ptr_d;
      lock_q     <= lock_d;
      lock_idx_q <= lock_idx_d;
    end
  end

endmodule

// File: rtl/wb_2x_line_en_sram_arbiter.sv
// Shares one line-enable SRAM between two Wishbone slave ports, one beat at a
// time: IDLE (grant) -> ACCESS (SRAM strobe) -> RESP (ACK) -> IDLE.
// Optional macro WB_SRAM_ARB_LOCK_EN: a master that keeps CYC high after its
// ACK keeps the grant until CYC falls.
//
// Handshake: a port requests while CYC&STB=1 and holds its request stable
// until it sees ACK=1 for exactly one cycle; a request that is not granted is
// simply held off (no ACK) and served in a later IDLE. ERR is never raised.
module wb_2x_line_en_sram_arbiter
  import wb_sram_arb_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 10,
  parameter int DATA_WIDTH    = 32
) (
  input  logic                        clk,
  input  logic                        rstn,
  wb_if.slave                         wb_s0,
  wb_if.slave                         wb_s1,
  generic_sram_line_en_if.sram_client sram_m,
  output arb_state_e                  dbg_state
);

  localparam int OFFS   = $clog2(DATA_WIDTH / 8);
  localparam int WORD_W = ADDRESS_WIDTH - OFFS;

  arb_state_e           state_q, state_d;
  arb_idx_t             idx_q, idx_d;
  logic                 we_q, we_d;
  logic [WORD_W-1:0]    addr_q, addr_d;
  logic                 re_q, re_d;
  logic                 wen_q, wen_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [NUM_PORTS-1:0] ack_q, ack_d;

  logic [NUM_PORTS-1:0] req, cyc;
  logic                 gnt_valid, upd_en, lock_in;
  arb_idx_t             gnt_idx;
  logic                 sel_we;
  logic [WORD_W-1:0]    sel_adr;
  logic [DATA_WIDTH-1:0] sel_dat;
  logic                 unused_ok;

  assign req = {wb_s1.cyc & wb_s1.stb, wb_s0.cyc & wb_s0.stb};
  assign cyc = {wb_s1.cyc, wb_s0.cyc};

  // Byte-lane selects are ignored (full-word writes) and byte offset bits are dropped.
  assign unused_ok = ^{wb_s0.sel, wb_s1.sel, wb_s0.adr[OFFS-1:0], wb_s1.adr[OFFS-1:0]};

  // Lock the grant when the owner still holds CYC as its beat completes.
`ifdef WB_SRAM_ARB_LOCK_EN
  assign lock_in = cyc[idx_q];
`else
  assign lock_in = 1'b0;
`endif

  wb_sram_arb_rr u_rr (
    .clk      (clk),
    .rstn     (rstn),
    .req      (req),
    .cyc      (cyc),
    .upd_en   (upd_en),
    .upd_idx  (idx_q),
    .lock_in  (lock_in),
    .gnt_valid(gnt_valid),
    .gnt_idx  (gnt_idx)
  );

  // Mux the granted port's command fields.
  always_comb begin
    sel_we  = gnt_idx ? wb_s1.we : wb_s0.we;
    sel_adr = gnt_idx ? wb_s1.adr[ADDRESS_WIDTH-1:OFFS] : wb_s0.adr[ADDRESS_WIDTH-1:OFFS];
    sel_dat = gnt_idx ? wb_s1.dat_w : wb_s0.dat_w;
  end

  // FSM next state and next register values; strobes default to idle each cycle.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    we_d    = we_q;
    addr_d  = '0;
    re_d    = 1'b0;
    wen_d   = 1'b0;
    wdata_d = '0;
    ack_d   = '0;
    upd_en  = 1'b0;
    case (state_q)
      IDLE: begin
        if (gnt_valid) begin
          idx_d   = gnt_idx;
          we_d    = sel_we;
          addr_d  = sel_adr;
          wdata_d = sel_dat;
          re_d    = !sel_we;
          wen_d   = sel_we;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        // An owner that dropped CYC mid-beat still gets its SRAM access, but no ACK.
        ack_d[idx_q] = cyc[idx_q];
        state_d      = RESP;
      end
      RESP: begin
        upd_en  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, SRAM output and ACK registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      idx_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      re_q    <= 1'b0;
      wen_q   <= 1'b0;
      wdata_q <= '0;
      ack_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      re_q    <= re_d;
      wen_q   <= wen_d;
      wdata_q <= wdata_d;
      ack_q   <= ack_d;
    end
  end

  assign sram_m.addr       = addr_q;
  assign sram_m.read_en    = re_q;
  assign sram_m.write_en   = wen_q;
  assign sram_m.write_data = wdata_q;

  // Read data is valid from the SRAM during RESP, alongside the registered ACK.
  assign wb_s0.ack   = ack_q[0];
  assign wb_s1.ack   = ack_q[1];
  assign wb_s0.dat_r = (ack_q[0] && !we_q) ? sram_m.read_data : '0;
  assign wb_s1.dat_r = (ack_q[1] && !we_q) ? sram_m.read_data : '0;
  assign wb_s0.err   = 1'b0;
  assign wb_s1.err   = 1'b0;

  assign dbg_state = state_q;

endmodule
